// File: rtl/rr_arb_4_1.sv
// rr_arb_4_1: 4-requester round-robin arbiter feeding a one-entry registered
// output stage. out_sel carries the winner index for a downstream 4:1 mux.
// Optional feature: define RR_ARB_STATS_EN to add the grant_cnt[7:0] port,
// a wrapping count of accepted input transfers.
module rr_arb_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
`ifdef RR_ARB_STATS_EN
    ,
    output logic [7:0]   grant_cnt
`endif
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic [1:0]   out_sel_q,   out_sel_d;
    logic [1:0]   ptr_q,       ptr_d;
`ifdef RR_ARB_STATS_EN
    logic [7:0]   grant_cnt_q, grant_cnt_d;
`endif

    logic         found;
    logic [1:0]   grant_idx;
    logic [1:0]   idx;
    logic         accept;
    logic         xfer;
    logic [W-1:0] grant_data;

    // Search from ptr upward (mod 4) for the first valid requester.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        found     = 1'b0;
        grant_idx = 2'd0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && in_valid[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Output slot can take a word when empty or being drained; never during reset.
    always_comb begin
        accept   = !out_valid_q || out_ready;
        xfer     = found && accept && !rst;
        in_ready = xfer ? 4'(4'b0001 << grant_idx) : 4'b0000;
    end

    // Word mux: only the granted input is looked at, so X on other inputs cannot leak.
    always_comb begin
        grant_data = d0;
        case (grant_idx)
            2'd0:    grant_data = d0;
            2'd1:    grant_data = d1;
            2'd2:    grant_data = d2;
            default: grant_data = d3;
        endcase
    end

    // Next state of the output slot, pointer and optional counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_STATS_EN
        grant_cnt_d = grant_cnt_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            ptr_d       = grant_idx + 2'd1;
`ifdef RR_ARB_STATS_EN
            grant_cnt_d = grant_cnt_q + 8'd1;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
            ptr_q       <= 2'd0;
`ifdef RR_ARB_STATS_EN
            grant_cnt_q <= 8'd0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_STATS_EN
            grant_cnt_q <= grant_cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef RR_ARB_STATS_EN
    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_4_1.sv
// Directed testbench for rr_arb_4_1 (W=4). Inputs change 1ns after the rising
// edge; outputs are sampled 2ns after the edge, well away from it.
module tb_rr_arb_4_1;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
`ifdef RR_ARB_STATS_EN
    logic [7:0]   grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    rr_arb_4_1 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
`ifdef RR_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1ns after the edge so inputs can be driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 4'h0;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        tick();
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        n_checks++;
        if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel got %0d want 0", out_sel); end
        n_checks++;
        if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst = 1'b0;
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]   exp_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [W-1:0] exp_data [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        do_reset();
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'(4'b0001 << exp_sel[i])) begin
                n_fail++; $display("FAIL rr_in_ready[%0d] got %b want sel %0d", i, in_ready, exp_sel[i]);
            end
            tick();
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== exp_data[i]) begin
                n_fail++;
                $display("FAIL rr_out[%0d] got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, exp_sel[i], exp_data[i]);
            end
        end
        in_valid = 4'h0;
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain got v=%b want 0", out_valid); end
    endtask

    task automatic test_pattern_1010();
        logic [1:0]   exp_sel  [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3};
        logic [W-1:0] exp_data [6] = '{4'h7, 4'h3, 4'h7, 4'h3, 4'h3, 4'h3};
        do_reset();
        d0 = 4'h0; d1 = 4'h7; d2 = 4'h0; d3 = 4'h3;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 4) ? 4'b1010 : 4'b1000;
            tick();
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== exp_data[i]) begin
                n_fail++;
                $display("FAIL p1010[%0d] got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, exp_sel[i], exp_data[i]);
            end
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        d0 = 4'h1; d1 = 4'h2; d2 = 4'hC; d3 = 4'hD;
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_empty_ready got %b want 0100", in_ready); end
        tick();
        in_valid = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (in_ready !== 4'h0 || out_valid !== 1'b1 || out_data !== 4'hC || out_sel !== 2'd2) begin
                n_fail++;
                $display("FAIL bp_stall[%0d] got rdy=%b v=%b data=%h sel=%0d want rdy=0000 v=1 data=c sel=2",
                         i, in_ready, out_valid, out_data, out_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready got %b want 1000", in_ready); end
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'hD) begin
            n_fail++;
            $display("FAIL bp_release_out got v=%b sel=%0d data=%h want v=1 sel=3 data=d", out_valid, out_sel, out_data);
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_x_isolation();
        logic [W-1:0] exp_data [6] = '{4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4};
        do_reset();
        d0 = 4'h1; d1 = 4'h2; d2 = 4'h4; d3 = 'x;
        in_valid  = 4'b0111;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            n_checks++;
            if ($isunknown(out_data) || out_data !== exp_data[i]) begin
                n_fail++; $display("FAIL xiso[%0d] got data=%h want %h", i, out_data, exp_data[i]);
            end
        end
        in_valid = 4'h0;
        d3 = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d0 = 4'h5; d1 = 4'h6; d2 = 4'h0; d3 = 4'h9;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1) begin
            n_fail++; $display("FAIL rmid_hold got v=%b sel=%0d want v=1 sel=1", out_valid, out_sel);
        end
        rst      = 1'b1;
        in_valid = 4'b1001;
        #1;
        n_checks++;
        if (in_ready !== 4'h0) begin n_fail++; $display("FAIL rmid_rst_ready got %b want 0000", in_ready); end
        tick();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped got v=%b want 0", out_valid); end
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_ready got %b want 0001", in_ready); end
        tick();
        #1;
        n_checks++;
        if (out_sel !== 2'd0 || out_data !== 4'h5) begin
            n_fail++; $display("FAIL rmid_grant got sel=%0d data=%h want sel=0 data=5", out_sel, out_data);
        end
        in_valid = 4'h0;
        tick();
    endtask

`ifdef RR_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        n_checks++;
        if (grant_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_reset got %0d want 0", grant_cnt); end
        in_valid  = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        in_valid = 4'h0;
        #1;
        n_checks++;
        if (grant_cnt !== 8'd4) begin n_fail++; $display("FAIL stats_wrap got %0d want 4", grant_cnt); end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 4'h0; out_ready = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        test_reset();
        test_round_robin();
        test_pattern_1010();
        test_backpressure();
        test_x_isolation();
        test_reset_mid();
`ifdef RR_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
